// File: rtl/mdu_unit_if.sv
// Issue/result bus between the controller and the multiply/divide unit.
interface mdu_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, input busy, hi, lo);
  modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. The result is computed
// at the issue edge and held in a pending register; HI/LO are only updated
// when the busy window closes, so the controller sees a fixed-latency unit.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_unit_if.slave  bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [63:0] pend;
  logic [31:0] hi_r, lo_r;
  logic        busy_o, accept_md, accept_mthi, accept_mtlo, finish;

  // Full 64-bit {hi,lo} result for mult/multu/div/divu.
  function automatic logic [63:0] calc(input logic [2:0] f_op,
                                       input logic [31:0] x,
                                       input logic [31:0] y);
    logic signed [63:0] prod_s;
    logic signed [31:0] quo_s, rem_s;
    logic [63:0]        res;
    res    = '0;
    prod_s = '0;
    quo_s  = '0;
    rem_s  = '0;
    case (f_op)
      3'd0: begin
        prod_s = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        res    = prod_s;
      end
      3'd1: res = {32'd0, x} * {32'd0, y};
      3'd2: begin
        if (y == 32'd0)
          res = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
          // The one signed overflow: quotient wraps to itself, no trap.
          res = {32'd0, 32'h8000_0000};
        else begin
          quo_s = $signed(x) / $signed(y);
          rem_s = $signed(x) % $signed(y);
          res   = {rem_s, quo_s};
        end
      end
      3'd3: begin
        if (y == 32'd0)
          res = {x, 32'hFFFF_FFFF};
        else
          res = {x % y, x / y};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: leave IDLE on an accepted mult/div, return when the count expires.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_md) state_nxt = BUSY;
      BUSY:    if (finish)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/decode logic: strobes are only honoured in IDLE, so issues while busy vanish.
  always_comb begin
    busy_o      = (state == BUSY);
    accept_md   = (state == IDLE) && bus.start && (bus.op <= 3'd3);
    accept_mthi = (state == IDLE) && bus.start && (bus.op == 3'd4);
    accept_mtlo = (state == IDLE) && bus.start && (bus.op == 3'd5);
    finish      = (state == BUSY) && (cnt == 5'd1);
  end

  // Cycle counter: loaded at issue, counts down once per edge while busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (accept_md)
      cnt <= bus.op[1] ? DIV_N : MULT_N;
    else if (state == BUSY)
      cnt <= cnt - 5'd1;
  end

  // Pending result captured with the operands present at the issue edge.
  always_ff @(posedge clk) begin
    if (accept_md) pend <= calc(bus.op, bus.a, bus.b);
  end

  // HI/LO: committed from the pending result as busy drops, or written directly by mthi/mtlo.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (finish) begin
      hi_r <= pend[63:32];
      lo_r <= pend[31:0];
    end else if (accept_mthi) begin
      hi_r <= bus.a;
    end else if (accept_mtlo) begin
      lo_r <= bus.a;
    end
  end

  assign bus.busy = busy_o;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: the driver pushes expected HI/LO and busy
// length for each accepted operation; a monitor pops and compares them.
module tb_mdu_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mdu_unit_if bus();

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          n;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errs   = 0;
  logic [31:0] model_hi = '0, model_lo = '0;
  logic [31:0] vis_hi = '0, vis_lo = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Reference arithmetic from the architectural rules, using 64-bit integers.
  function automatic logic [63:0] ref_calc(input logic [2:0] o, input logic [31:0] x,
                                           input logic [31:0] y);
    longint sa, sb, qv, r, ma, mb;
    logic [63:0] ux, uy;
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      3'd0: begin
        sa = longint'(int'(x));
        sb = longint'(int'(y));
        r  = sa * sb;
        return r;
      end
      3'd1: return ux * uy;
      3'd2: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        sa = longint'(int'(x));
        sb = longint'(int'(y));
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        qv = ma / mb;
        if ((sa < 0) != (sb < 0)) qv = -qv;
        r = sa - qv * sb;
        return {r[31:0], qv[31:0]};
      end
      3'd3: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {32'(ux % uy), 32'(ux / uy)};
      end
      default: return '0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Drive one strobe (called at negedge+1) and record what it should produce.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] r;
    exp_t e;
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    if (o <= 3'd3) begin
      r = ref_calc(o, x, y);
      model_hi = r[63:32];
      model_lo = r[31:0];
      e.n = (o < 3'd2) ? MC : DC;
      e.hi = model_hi;
      e.lo = model_lo;
      q.push_back(e);
    end else if (o == 3'd4 || o == 3'd5) begin
      if (o == 3'd4) model_hi = x;
      else           model_lo = x;
      e.n = 0;
      e.hi = model_hi;
      e.lo = model_lo;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Wait for idle; optionally disturb operands and strobe while busy.
  task automatic wait_idle(input bit wig);
    bit done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      bus.start = 1'b0;
      if (!bus.busy) begin
        done = 1'b1;
        break;
      end
      if (wig) begin
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.op    = 3'($urandom_range(0, 7));
        bus.start = 1'($urandom_range(0, 1));
      end
    end
    if (!done) begin
      checks++;
      errs++;
      $display("FAIL idle_timeout: busy still %b after 40 cycles, expected 0", bus.busy);
    end
  endtask

  // Monitor: compares HI/LO when busy falls or after an accepted move.
  initial begin
    bit   prev_busy = 1'b0;
    bit   pend_move = 1'b0;
    int   cnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        prev_busy = 1'b0;
        pend_move = 1'b0;
        cnt = 0;
        continue;
      end
      if (pend_move) begin
        pend_move = 1'b0;
        if (q.size() == 0) begin
          checks++; errs++;
          $display("FAIL move_queue: got empty queue, expected an entry");
        end else begin
          e = q.pop_front();
          chk("move_kind", e.n, 0);
          chk("move_hi", bus.hi, e.hi);
          chk("move_lo", bus.lo, e.lo);
          chk("move_busy", {31'd0, bus.busy}, 32'd0);
          vis_hi = e.hi;
          vis_lo = e.lo;
        end
      end
      if (bus.start && !bus.busy && (bus.op == 3'd4 || bus.op == 3'd5))
        pend_move = 1'b1;
      if (bus.busy) begin
        cnt++;
        chk("hold_hi", bus.hi, vis_hi);
        chk("hold_lo", bus.lo, vis_lo);
      end else if (prev_busy) begin
        if (q.size() == 0) begin
          checks++; errs++;
          $display("FAIL result_queue: got empty queue, expected an entry");
        end else begin
          e = q.pop_front();
          chk("busy_len", cnt, e.n);
          chk("result_hi", bus.hi, e.hi);
          chk("result_lo", bus.lo, e.lo);
          vis_hi = e.hi;
          vis_lo = e.lo;
        end
        cnt = 0;
      end
      prev_busy = bus.busy;
    end
  end

  // Stimulus.
  initial begin
    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    #3;
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);
    @(negedge clk);
    #3 reset = 1'b0;
    @(negedge clk);
    #1;

    issue(3'd0, 32'hFFFF_FFFD, 32'd5);          wait_idle(1'b0);
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);          wait_idle(1'b0);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);          wait_idle(1'b0);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);  wait_idle(1'b0);
    issue(3'd3, 32'h0000_1234, 32'd0);          wait_idle(1'b0);
    issue(3'd4, 32'hCAFE_F00D, 32'd0);          wait_idle(1'b0);

    // mtlo strobe in the second busy cycle of a mult must be dropped.
    issue(3'd0, 32'd3, 32'd4);
    @(negedge clk);
    @(negedge clk);
    #1;
    bus.start = 1'b1;
    bus.op    = 3'd5;
    bus.a     = 32'hDEAD;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_idle(1'b0);

    // Asynchronous reset in the fourth busy cycle of a div.
    issue(3'd4, 32'h5A5A_5A5A, 32'd0);          wait_idle(1'b0);
    issue(3'd2, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset_busy", {31'd0, bus.busy}, 32'd0);
    chk("midreset_hi", bus.hi, 32'd0);
    chk("midreset_lo", bus.lo, 32'd0);
    q.delete();
    model_hi = '0; model_lo = '0;
    vis_hi = '0;   vis_lo = '0;
    @(negedge clk);
    #3 reset = 1'b0;
    repeat (15) @(negedge clk);
    #1;
    chk("stale_busy", {31'd0, bus.busy}, 32'd0);
    chk("stale_hi", bus.hi, 32'd0);
    chk("stale_lo", bus.lo, 32'd0);

    // Randomized back-to-back traffic with disturbance while busy.
    for (int i = 0; i < 60; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
      wait_idle(1'b1);
    end

    repeat (3) @(negedge clk);
    #1;
    chk("queue_empty", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers for the single-cycle MIPS datapath; executes mult, multu, div, divu, mthi, mtlo.
- Sits beside the ALU in the execute path: operands come from the register file, and HI/LO feed the mfhi/mflo writeback mux.
- Exports busy so the controller can stall the PC and instruction issue while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high for mult/multu (legal range 1..31).
- DIV_CYCLES, 10, cycles busy stays high for div/divu (legal range 1..31).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  issue strobe; sampled on a rising edge.
- op  input  3  operation: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 reserved.
- a  input  32  operand rs (dividend / multiplicand / mthi-mtlo source).
- b  input  32  operand rt (divisor / multiplier).
- busy  output  1  high while a mult/div is in flight.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (async, any time, including mid-operation): hi=0, lo=0, busy=0, counter=0, state=IDLE. Any in-flight result is discarded.
- States: IDLE and BUSY. An internal 5-bit counter and 64-bit pending-result register hold the in-flight operation.
- IDLE, start=1, op 0–3:
  - Compute the result from a/b at the issue edge and store it in the pending register.
  - Load the counter with MULT_CYCLES or DIV_CYCLES and go to BUSY.
  - busy=1 from the issue edge onward.
- BUSY:
  - Counter decrements every edge.
  - On the edge where the counter reaches 0, load hi/lo from the pending register, drive busy=0, and return to IDLE.
  - busy is high for exactly N cycles. New hi/lo are visible in the same cycle busy drops.
  - hi/lo hold their old values throughout BUSY.
- IDLE, start=1, op 4 (mthi): hi<=a on that edge. op 5 (mtlo): lo<=a on that edge. No busy; the other register is unchanged.
- start=1 with op 6/7: ignored, no state change.
- start=1 while BUSY (any op): ignored. The controller must stall, and the bench checks that the ignored strobe has no effect.
- Width and arithmetic rules:
  - mult: signed 32x32 -> 64; hi=[63:32], lo=[31:0].
  - multu: same split, unsigned.
  - div: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - div with 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
  - divu: unsigned quotient into lo, remainder into hi.
  - Divide by zero (div or divu): lo=0xFFFFFFFF, hi=a. Still takes DIV_CYCLES.
- Operands are captured only at the issue edge. Changes on a/b during BUSY have no effect.
- Back-to-back issue: start asserted in the cycle busy falls is accepted at the next edge, since the state is IDLE by then.

Test Plan:
- Signed mult: reset, then mult a=0xFFFFFFFD (-3), b=5 -> busy high exactly 5 cycles, hi=0xFFFFFFFF, lo=0xFFFFFFF1 when busy falls; hi/lo stay 0 during busy.
- Unsigned mult: multu a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
- Signed div and overflow case:
  - div a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero plus move-to: divu a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234. Then mthi a=0xCAFEF00D -> hi=0xCAFEF00D next edge, lo unchanged, busy never rises.
- Ignored issue while busy: issue mult 3*4; on cycle 2 assert start with op=5, a=0xDEAD -> ignored. Final hi=0, lo=0x0000000C.
- Reset mid-operation: assert reset asynchronously mid-cycle during a div's 4th busy cycle -> busy, hi, lo go to 0 immediately (before the next edge). After release, no stale result appears.
